uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick samples spanning the stop bit(s); 16 = 1 stop bit, 24 = 1.5, 32 = 2.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port rx  input  1  asynchronous serial line; idle high.
REQ-006 Port s_tick  input  1  16x oversampling strobe, one clk wide, from the baud-rate generator's max_tick.
REQ-007 Port rd_uart  input  1  consumer pops the holding register.
REQ-008 Port r_data  output  DBIT  received byte in the holding register.
REQ-009 Port rx_empty  output  1  high when the holding register holds no unread byte.
REQ-010 Port frame_err  output  1  stop-bit error flag of the byte in the holding register.
REQ-011 Port overrun  output  1  sticky flag: a completed byte was discarded because the holding register was full.
REQ-012 Port rx_done_tick  output  1  one-clk pulse when a frame completes.

Function
REQ-013 rx SHALL pass through a two-flop synchronizer (both flops reset to 1); rx_s denotes its output, giving 2 clk latency.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP, a 4-bit sample counter s, a bit counter n of width ceil(log2(DBIT)), and a DBIT-wide shift register b.
REQ-015 In IDLE, the FSM SHALL move to START with s=0 on the first clk where rx_s==0; s_tick is not required.
REQ-016 In START, on each s_tick with s==7, the FSM SHALL go to DATA with s=0, n=0 if rx_s==0, else return to IDLE (glitch rejection); on other s_ticks s SHALL increment.
REQ-017 In DATA, on each s_tick with s==15, the block SHALL set s=0, shift b={rx_s, b[DBIT-1:1]} (LSB first), and go to STOP if n==DBIT-1, else increment n; on other s_ticks s SHALL increment.
REQ-018 In STOP, on the s_tick with s==SB_TICK-1, the block SHALL return to IDLE, pulse rx_done_tick for exactly one clk, and capture ferr=~rx_s; on other s_ticks s SHALL increment.
REQ-019 The FSM and all counters SHALL hold in every clk without s_tick, except the IDLE->START transition.
REQ-020 On rx_done_tick with rx_empty==1, or with rd_uart==1 in the same clk, the block SHALL load b into r_data and ferr into frame_err, and clear rx_empty on the next clk.
REQ-021 On rx_done_tick with rx_empty==0 and rd_uart==0, the block SHALL discard the new byte, keep r_data/frame_err unchanged, and set overrun.
REQ-022 rd_uart with rx_empty==0 and no simultaneous done SHALL set rx_empty=1; overrun SHALL clear on any rd_uart with rx_empty==0.
REQ-023 rd_uart while rx_empty==1 SHALL be ignored with no state change.
REQ-024 A byte with a frame error SHALL still be delivered, with frame_err=1.

Reset
REQ-025 On reset, the block SHALL set the state to IDLE, s, n and b to 0, both synchronizer flops to 1, r_data to 0, rx_empty to 1, frame_err to 0, overrun to 0 and rx_done_tick to 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without a done pulse; reception SHALL restart only on a new falling edge after reset releases.

Verification
REQ-027 Scenario 1: s_tick every 54 clk; send 0xA5 (8N1, 16 ticks/bit) -> one rx_done_tick, r_data=0xA5, rx_empty=0, frame_err=0.
REQ-028 Scenario 2: rx low for 5 s_ticks, then high -> FSM returns to IDLE, no rx_done_tick, rx_empty stays 1.
REQ-029 Scenario 3: send 0x3C with the stop bit driven 0 -> r_data=0x3C, frame_err=1.
REQ-030 Scenario 4: send 0x11 and then 0x22 without rd_uart -> r_data=0x11, overrun=1; a following rd_uart gives rx_empty=1 and overrun=0.
REQ-031 Scenario 5: assert rd_uart in the same clk as the 0x22 done pulse while 0x11 is held -> r_data=0x22, rx_empty=0, overrun=0.
REQ-032 Scenario 6: assert reset during data bit 4 of 0xFF, then send 0x5A -> no done pulse for the aborted frame, next byte read is 0x5A.

Source files
------------

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sampler
//  Brief    : 16x-oversampled UART receiver with a one-entry holding register
//             and frame-error / overrun flags.
//  Revision : 1.0
// ============================================================================
module uart_rx_sampler #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   input  logic            rd_uart,
   output logic [DBIT-1:0] r_data,
   output logic            rx_empty,
   output logic            frame_err,
   output logic            overrun,
   output logic            rx_done_tick
);

   localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   // The sample counter widens only when the stop period exceeds 16 ticks.
   localparam int c_SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

   localparam logic [c_SW-1:0] c_S_MID  = c_SW'(7);
   localparam logic [c_SW-1:0] c_S_LAST = c_SW'(15);
   localparam logic [c_SW-1:0] c_S_STOP = c_SW'(SB_TICK - 1);
   localparam logic [c_SW-1:0] c_S_ONE  = c_SW'(1);
   localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBIT - 1);
   localparam logic [c_NW-1:0] c_N_ONE  = c_NW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   logic            r_rx_meta;
   logic            r_rx_s;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_SW-1:0] r_s;
   logic [c_SW-1:0] w_s_nxt;
   logic [c_NW-1:0] r_n;
   logic [c_NW-1:0] w_n_nxt;
   logic [DBIT-1:0] r_b;
   logic [DBIT-1:0] w_b_nxt;
   logic            r_ferr;
   logic            w_ferr_nxt;
   logic            w_done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_meta    <= 1'b1;
         r_rx_s       <= 1'b1;
         r_state      <= ST_IDLE;
         r_s          <= '0;
         r_n          <= '0;
         r_b          <= '0;
         r_ferr       <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         r_rx_meta    <= rx;
         r_rx_s       <= r_rx_meta;
         r_state      <= w_state_nxt;
         r_s          <= w_s_nxt;
         r_n          <= w_n_nxt;
         r_b          <= w_b_nxt;
         r_ferr       <= w_ferr_nxt;
         rx_done_tick <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_n_nxt     = r_n;
      w_b_nxt     = r_b;
      w_ferr_nxt  = r_ferr;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = ST_START;
               w_s_nxt     = '0;
            end
         end
         ST_START: begin
            if (s_tick) begin
               if (r_s == c_S_MID) begin
                  // A start bit that is no longer low at mid-bit is a glitch.
                  if (!r_rx_s) begin
                     w_state_nxt = ST_DATA;
                     w_s_nxt     = '0;
                     w_n_nxt     = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_s_nxt = r_s + c_S_ONE;
               end
            end
         end
         ST_DATA: begin
            if (s_tick) begin
               if (r_s == c_S_LAST) begin
                  w_s_nxt = '0;
                  w_b_nxt = {r_rx_s, r_b[DBIT-1:1]};
                  if (r_n == c_N_LAST) begin
                     w_state_nxt = ST_STOP;
                  end else begin
                     w_n_nxt = r_n + c_N_ONE;
                  end
               end else begin
                  w_s_nxt = r_s + c_S_ONE;
               end
            end
         end
         ST_STOP: begin
            if (s_tick) begin
               if (r_s == c_S_STOP) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
                  w_ferr_nxt  = ~r_rx_s;
               end else begin
                  w_s_nxt = r_s + c_S_ONE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Holding register: a completed byte is accepted when the slot is free or
   // is being read in the same cycle; otherwise it is dropped and flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data    <= '0;
         rx_empty  <= 1'b1;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (rx_done_tick) begin
            if (rx_empty || rd_uart) begin
               r_data    <= r_b;
               frame_err <= r_ferr;
               rx_empty  <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd_uart && !rx_empty) begin
            rx_empty <= 1'b1;
         end
         if (rd_uart && !rx_empty) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sampler.sv
`default_nettype none
// Scoreboard bench for uart_rx_sampler: the stimulus queues the expected
// holding-register contents, a monitor checks them after every done pulse.
module tb_uart_rx_sampler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       s_tick = 1'b0;
   logic       rd_uart = 1'b0;
   logic [7:0] r_data;
   logic       rx_empty;
   logic       frame_err;
   logic       overrun;
   logic       rx_done_tick;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int tick_div = 54;
   int tick_cnt = 0;
   bit pending = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      logic       empty;
      logic       ovr;
   } exp_t;
   exp_t q[$];

   uart_rx_sampler #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .rd_uart      (rd_uart),
      .r_data       (r_data),
      .rx_empty     (rx_empty),
      .frame_err    (frame_err),
      .overrun      (overrun),
      .rx_done_tick (rx_done_tick)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tick_cnt >= tick_div - 1) begin
         tick_cnt = 0;
         s_tick   = 1'b1;
      end else begin
         tick_cnt = tick_cnt + 1;
         s_tick   = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: results of a done pulse are visible one clk later.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         pending = 1'b0;
      end else begin
         if (pending) begin
            pending = 1'b0;
            if (q.size() == 0) begin
               total = total + 1;
               bad   = bad + 1;
               $display("FAIL unexpected_done: got done pulse expected none at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("r_data",    32'(r_data),    32'(e.data));
               chk("frame_err", 32'(frame_err), 32'(e.ferr));
               chk("rx_empty",  32'(rx_empty),  32'(e.empty));
               chk("overrun",   32'(overrun),   32'(e.ovr));
            end
         end
         if (rx_done_tick) begin
            done_cnt = done_cnt + 1;
            pending  = 1'b1;
         end
      end
   end

   task automatic wait_ticks(input int k);
      for (int i = 0; i < k; i++) begin
         int g = 0;
         do begin
            @(posedge clk);
            g++;
         end while (!s_tick && g < 1000);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      @(negedge clk) rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk) rx = d[i];
         wait_ticks(16);
      end
      // Stop level covers the mid-bit sample, then the line returns idle
      // early enough that a low stop bit cannot be taken as a new start.
      @(negedge clk) rx = stop;
      wait_ticks(12);
      @(negedge clk) rx = 1'b1;
      wait_ticks(8);
   endtask

   task automatic rd_pulse();
      @(negedge clk) rd_uart = 1'b1;
      @(negedge clk) rd_uart = 1'b0;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_r_data",    32'(r_data),       32'h0);
      chk("rst_rx_empty",  32'(rx_empty),     32'h1);
      chk("rst_frame_err", 32'(frame_err),    32'h0);
      chk("rst_overrun",   32'(overrun),      32'h0);
      chk("rst_done",      32'(rx_done_tick), 32'h0);

      // Scenario 1: 0xA5 at 54 clk per tick
      q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
      send_byte(8'hA5, 1'b1);
      chk("s1_done_cnt", 32'(done_cnt), 32'd1);
      rd_pulse();
      chk("s1_rd_empty", 32'(rx_empty), 32'h1);

      tick_div = 20;
      wait_ticks(2);

      // Scenario 2: short low glitch
      @(negedge clk) rx = 1'b0;
      wait_ticks(5);
      @(negedge clk) rx = 1'b1;
      wait_ticks(20);
      chk("s2_done_cnt", 32'(done_cnt), 32'd1);
      chk("s2_empty",    32'(rx_empty), 32'h1);

      // Scenario 3: framing error still delivers the byte
      q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
      send_byte(8'h3C, 1'b0);
      chk("s3_done_cnt", 32'(done_cnt), 32'd2);
      rd_pulse();

      // Scenario 4: overrun
      q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      send_byte(8'h11, 1'b1);
      q.push_back('{8'h11, 1'b0, 1'b0, 1'b1});
      send_byte(8'h22, 1'b1);
      chk("s4_done_cnt", 32'(done_cnt), 32'd4);
      rd_pulse();
      chk("s4_rd_empty",   32'(rx_empty), 32'h1);
      chk("s4_rd_overrun", 32'(overrun),  32'h0);

      // Scenario 5: read coincident with done replaces the held byte
      q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      send_byte(8'h11, 1'b1);
      q.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
      fork
         send_byte(8'h22, 1'b1);
         begin
            int g = 0;
            @(negedge clk);
            while (!rx_done_tick && g < 20000) begin
               @(negedge clk);
               g++;
            end
            total = total + 1;
            if (g >= 20000) begin
               bad = bad + 1;
               $display("FAIL s5_done_timeout: got no done expected done pulse");
            end else begin
               rd_uart = 1'b1;
               @(negedge clk) rd_uart = 1'b0;
            end
         end
      join
      chk("s5_done_cnt", 32'(done_cnt), 32'd6);
      chk("s5_overrun",  32'(overrun),  32'h0);
      rd_pulse();
      chk("s5_rd_empty", 32'(rx_empty), 32'h1);

      // Scenario 6: reset during data bit 4 of 0xFF
      @(negedge clk) rx = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk) rx = 1'b1;
         wait_ticks(16);
      end
      wait_ticks(8);
      @(negedge clk) begin
         reset = 1'b1;
         rx    = 1'b1;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_ticks(20);
      chk("s6_abort_done_cnt", 32'(done_cnt), 32'd6);
      chk("s6_abort_empty",    32'(rx_empty), 32'h1);
      q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
      send_byte(8'h5A, 1'b1);
      chk("s6_done_cnt", 32'(done_cnt), 32'd7);
      rd_pulse();
      chk("s6_rd_empty", 32'(rx_empty), 32'h1);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
